rle_symbolizer: RTL and testbench
=================================

// Module: rle_symbolizer
// PURPOSE
//  JPEG entropy front end. Consumes one 8x8 block of quantized coefficients in
//  zigzag order and emits Huffman symbols to the downstream Huffman coder.
//  Per block, symbols are emitted in this order:
//   - one DC symbol;
//   - AC (run,size,value) symbols, with ZRL (15,0) inserted for runs >= 16;
//   - EOB (0,0), unless coefficient 63 is nonzero.
//  AC values are output as ones-complement magnitude bits. DC is passed raw;
//  DC differencing is done downstream.
// PARAMETERS
//  BLOCK_LEN  64  coefficients per block. Power of two, >=2. Non-64 values are for test only.
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous, active-high reset
//  coef_ena_in   in   1   coefficient valid
//  coef_rdy_out  out  1   coefficient ready; transfer when coef_ena_in && coef_rdy_out
//  coef          in   11  signed quantized coefficient, zigzag order, valid range -1023..1023
//  coef_last     in   1   sampled on coefficient 0: this block is the last of the scan
//  ena_out       out  1   symbol valid; held high until accepted
//  rdy_in        in   1   downstream ready; symbol transfers when ena_out && rdy_in
//  dc            out  1   symbol is DC
//  out_dc        out  11  signed raw DC coefficient; 0 when dc=0
//  run           out  4   AC zero run (15 for ZRL)
//  size          out  4   AC magnitude category 0..10 (0 for EOB/ZRL/DC)
//  val           out  10  AC ones-complement value bits, zero-extended above size
//  flush         out  1   qualifies the final symbol of the last block (valid with ena_out)
// BEHAVIOUR
//  Reset:
//   - ena_out=0, all symbol outputs 0, coef_rdy_out=0 in the reset cycle.
//   - Index=0, zero_run=0, state S_RUN.
//   - Reset mid-block discards the partial block; the next accepted coefficient is DC.
//  Registers: idx (0..BLOCK_LEN-1, wraps to 0 after the last coefficient), zero_run (6b),
//   pend_coef, last_blk, and the output symbol register.
//  coef_rdy_out = (state==S_RUN) && !ena_out. Combinational from registers only.
//  Latency: a coefficient accepted in cycle t produces its symbol with ena_out=1 at t+1.
//  A zero AC produces no symbol, so zeros stream at 1 per cycle.
//  Transfer: when ena_out && rdy_in, ena_out drops next cycle unless another symbol is loaded.
//   - Outputs stay stable while ena_out=1 && rdy_in=0.
//   - ena_out never depends combinationally on rdy_in.
//  On accept, in S_RUN:
//   - idx==0: load DC {dc=1, out_dc=coef, run=0, size=0, val=0}. zero_run<=0. last_blk<=coef_last.
//   - idx>0, coef==0:
//     - zero_run++.
//     - If idx==BLOCK_LEN-1, load EOB instead. Pending zeros are discarded and no ZRL is emitted.
//   - idx>0, coef!=0:
//     - zero_run<16: load {run=zero_run, size, val}; zero_run<=0.
//     - zero_run>=16: pend_coef<=coef, load ZRL, go to S_ZRL.
//  S_ZRL: on each ZRL transfer, zero_run-=16.
//   - If still >=16, load the next ZRL.
//   - Otherwise load the pending symbol with run=zero_run, set zero_run<=0, return to S_RUN.
//  Size/val rules:
//   - m=|coef|; size=bit length of m (1..10).
//   - val = coef>0 ? coef : coef-1, truncated to size bits.
//   - -1024 saturates to -1023.
//  EOB is suppressed if coefficient BLOCK_LEN-1 is nonzero; the block then ends on that AC symbol.
//  flush=1 on the block's final symbol (EOB, or the final AC symbol) when last_blk=1. Else 0.
//  Simultaneous transfer and new accept cannot occur, because coef_rdy_out requires !ena_out.
//  States: S_RUN (accepting), S_ZRL (emitting ZRLs plus the pending symbol). No other states.
// TESTING
//  1. DC=50, 63 zero ACs, rdy_in=1 -> {dc=1, out_dc=50}, then EOB {run=0, size=0}. Exactly 2 transfers.
//  2. AC1=-3, AC2=5, rest 0 -> symbols in order:
//     - (run=0, size=2, val=2'b00)
//     - (0, 3, 3'b101)
//     - EOB
//  3. AC40=1, other ACs 0 -> ZRL, ZRL, (7,1,1), EOB. coef_rdy_out=0 throughout S_ZRL.
//  4. AC63=-1, other ACs 0 -> ZRL x3, then (14,1,0). No EOB. With coef_last=1, flush=1 on (14,1,0) only.
//  5. rdy_in held 0 for 10 cycles with a symbol valid:
//     - outputs stable, coef_rdy_out=0;
//     - after release, exact symbol sequence with no loss or duplication.
//  6. Reset at idx=20, then a new block with DC=-7 -> first transfer {dc=1, out_dc=-7}.
//     AC1=1023 -> (0,10,10'h3FF); AC1=-1024 -> (0,10,0).

Source files
------------

// File: rtl/rle_symbolizer_if.sv
// Coefficient-in and symbol-out handshakes for the JPEG RLE symbolizer.
// slave is the symbolizer side; master drives coefficients and sinks symbols.
interface rle_symbolizer_if;
  logic               coef_ena_in;
  logic               coef_rdy_out;
  logic signed [10:0] coef;
  logic               coef_last;
  logic               ena_out;
  logic               rdy_in;
  logic               dc;
  logic signed [10:0] out_dc;
  logic [3:0]         run;
  logic [3:0]         size;
  logic [9:0]         val;
  logic               flush;

  modport slave (
    input  coef_ena_in, coef, coef_last, rdy_in,
    output coef_rdy_out, ena_out, dc, out_dc,
    output run, size, val, flush
  );

  modport master (
    output coef_ena_in, coef, coef_last, rdy_in,
    input  coef_rdy_out, ena_out, dc, out_dc,
    input  run, size, val, flush
  );
endinterface

// File: rtl/rle_symbolizer.sv
// JPEG entropy front end: turns a zigzag coefficient block into
// DC, AC (run,size,value), ZRL and EOB symbols.
module rle_symbolizer #(
  parameter int BLOCK_LEN = 64
) (
  input logic         clk,
  input logic         rst,
  rle_symbolizer_if.slave bus
);
  localparam int IW = $clog2(BLOCK_LEN);
  localparam logic [IW-1:0] LAST = IW'(BLOCK_LEN - 1);

  typedef enum logic {S_RUN, S_ZRL} state_t;

  typedef struct packed {
    logic               ena;
    logic               dc;
    logic signed [10:0] odc;
    logic [3:0]         run;
    logic [3:0]         size;
    logic [9:0]         val;
    logic               flush;
  } sym_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [5:0]         zrun_q, zrun_d;
  logic signed [10:0] pend_q, pend_d;
  logic               pend_end_q, pend_end_d;
  logic               last_q, last_d;
  sym_t               sym_q, sym_d;

  logic               acc, xfer;
  logic signed [10:0] src, sat;
  logic [9:0]         mag, vv, vl;
  logic [3:0]         sz;
  logic [5:0]         zr;

  assign bus.coef_rdy_out = !rst && (state_q == S_RUN)
                            && !sym_q.ena;
  assign acc  = bus.coef_ena_in && bus.coef_rdy_out;
  assign xfer = sym_q.ena && bus.rdy_in;

  assign bus.ena_out = sym_q.ena;
  assign bus.dc      = sym_q.dc;
  assign bus.out_dc  = sym_q.odc;
  assign bus.run     = sym_q.run;
  assign bus.size    = sym_q.size;
  assign bus.val     = sym_q.val;
  assign bus.flush   = sym_q.flush;

  // Category and ones-complement bits of the coefficient being coded
  always_comb begin
    src = (state_q == S_ZRL) ? pend_q : bus.coef;
    sat = (src == 11'h400) ? 11'h401 : src;
    mag = sat[10] ? 10'(-sat) : sat[9:0];
    sz  = 4'd0;
    for (int i = 0; i < 10; i++)
      if (mag[i]) sz = 4'(i + 1);
    vv = sat[10] ? 10'(sat - 11'sd1) : sat[9:0];
    vl = vv & ((10'd1 << sz) - 10'd1);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    zrun_d     = zrun_q;
    pend_d     = pend_q;
    pend_end_d = pend_end_q;
    last_d     = last_q;
    sym_d      = sym_q;
    zr         = zrun_q - 6'd16;
    if (xfer) sym_d.ena = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (acc) begin
          idx_d     = idx_q + IW'(1);
          sym_d     = '0;
          sym_d.ena = 1'b1;
          if (idx_q == '0) begin
            sym_d.dc  = 1'b1;
            sym_d.odc = bus.coef;
            zrun_d    = 6'd0;
            last_d    = bus.coef_last;
          end else if (bus.coef == '0) begin
            if (idx_q == LAST) begin
              zrun_d      = 6'd0;
              sym_d.flush = last_q;
            end else begin
              sym_d.ena = 1'b0;
              zrun_d    = zrun_q + 6'd1;
            end
          end else if (zrun_q < 6'd16) begin
            sym_d.run   = zrun_q[3:0];
            sym_d.size  = sz;
            sym_d.val   = vl;
            sym_d.flush = last_q && (idx_q == LAST);
            zrun_d      = 6'd0;
          end else begin
            sym_d.run  = 4'd15;
            pend_d     = bus.coef;
            pend_end_d = (idx_q == LAST);
            state_d    = S_ZRL;
          end
        end
      end
      S_ZRL: begin
        if (xfer) begin
          sym_d     = '0;
          sym_d.ena = 1'b1;
          if (zr >= 6'd16) begin
            sym_d.run = 4'd15;
            zrun_d    = zr;
          end else begin
            sym_d.run   = zr[3:0];
            sym_d.size  = sz;
            sym_d.val   = vl;
            sym_d.flush = last_q && pend_end_q;
            zrun_d      = 6'd0;
            state_d     = S_RUN;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      idx_q      <= '0;
      zrun_q     <= '0;
      pend_q     <= '0;
      pend_end_q <= 1'b0;
      last_q     <= 1'b0;
      sym_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      zrun_q     <= zrun_d;
      pend_q     <= pend_d;
      pend_end_q <= pend_end_d;
      last_q     <= last_d;
      sym_q      <= sym_d;
    end
  end
endmodule

// File: tb/tb_rle_symbolizer.sv
// Scoreboard bench for rle_symbolizer: directed blocks,
// expected symbols queued at stimulus time, popped by a monitor.
module tb_rle_symbolizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rle_symbolizer_if bus();

  rle_symbolizer #(.BLOCK_LEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit dc;
    int odc;
    int run;
    int size;
    int val;
    bit fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   blk[64];

  function automatic void push(bit d, int o, int r,
                               int s, int v, bit f);
    exp_t e;
    e.dc = d; e.odc = o; e.run = r;
    e.size = s; e.val = v; e.fl = f;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.ena_out) begin
      checks++;
      if (bus.coef_rdy_out !== 1'b0) begin
        errors++;
        $display("FAIL rdy_while_valid got=%b exp=0",
                 bus.coef_rdy_out);
      end
      if (bus.rdy_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_symbol got dc=%b odc=%0d run=%0d size=%0d val=%h fl=%b exp none",
                   bus.dc, bus.out_dc, bus.run, bus.size,
                   bus.val, bus.flush);
        end else begin
          me = exp_q.pop_front();
          if ($isunknown({bus.dc, bus.out_dc, bus.run,
                          bus.size, bus.val, bus.flush})
              || bus.dc !== me.dc
              || int'(bus.out_dc) != me.odc
              || int'(bus.run) != me.run
              || int'(bus.size) != me.size
              || int'(bus.val) != me.val
              || bus.flush !== me.fl) begin
            errors++;
            $display("FAIL symbol got dc=%b odc=%0d run=%0d size=%0d val=%h fl=%b exp dc=%b odc=%0d run=%0d size=%0d val=%h fl=%b",
                     bus.dc, bus.out_dc, bus.run, bus.size,
                     bus.val, bus.flush, me.dc, me.odc,
                     me.run, me.size, me.val, me.fl);
          end
        end
      end
    end
  end

  task automatic send(input int c, input bit last);
    int n = 0;
    bus.coef_ena_in = 1'b1;
    bus.coef        = 11'(c);
    bus.coef_last   = last;
    forever begin
      @(negedge clk);
      if (bus.coef_rdy_out) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got rdy=0 exp rdy=1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.coef_ena_in = 1'b0;
  endtask

  task automatic send_block(input bit last);
    for (int i = 0; i < 64; i++) send(blk[i], last);
  endtask

  task automatic clr();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d exp=0",
               exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string nm);
    checks++;
    if ({bus.ena_out, bus.coef_rdy_out, bus.dc,
         bus.out_dc, bus.run, bus.size, bus.val,
         bus.flush} !== '0) begin
      errors++;
      $display("FAIL %s got ena=%b rdy=%b dc=%b odc=%0d run=%0d size=%0d val=%h fl=%b exp all 0",
               nm, bus.ena_out, bus.coef_rdy_out, bus.dc,
               bus.out_dc, bus.run, bus.size, bus.val,
               bus.flush);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    bus.coef_ena_in = 1'b0;
    bus.coef        = '0;
    bus.coef_last   = 1'b0;
    bus.rdy_in      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: DC only, then EOB
    clr(); blk[0] = 50;
    push(1, 50, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0);
    send_block(0); drain();

    // 2: two small ACs, last block so EOB flushes
    clr(); blk[1] = -3; blk[2] = 5;
    push(1, 0, 0, 0, 0, 0);
    push(0, 0, 0, 2, 0, 0);
    push(0, 0, 0, 3, 5, 0);
    push(0, 0, 0, 0, 0, 1);
    send_block(1); drain();

    // 3: long run at AC40
    clr(); blk[0] = 12; blk[40] = 1;
    push(1, 12, 0, 0, 0, 0);
    push(0, 0, 15, 0, 0, 0);
    push(0, 0, 15, 0, 0, 0);
    push(0, 0, 7, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0);
    send_block(0); drain();

    // 4: only AC63, block ends without EOB
    clr(); blk[0] = -5; blk[63] = -1;
    push(1, -5, 0, 0, 0, 0);
    push(0, 0, 15, 0, 0, 0);
    push(0, 0, 15, 0, 0, 0);
    push(0, 0, 15, 0, 0, 0);
    push(0, 0, 14, 1, 0, 1);
    send_block(1); drain();

    // 5: downstream stall with a symbol held
    clr(); blk[0] = 9; blk[1] = 2; blk[5] = -8;
    push(1, 9, 0, 0, 0, 0);
    push(0, 0, 0, 2, 2, 0);
    push(0, 0, 3, 4, 7, 0);
    push(0, 0, 0, 0, 0, 0);
    bus.rdy_in = 1'b0;
    fork
      send_block(0);
      begin
        int n = 0;
        while (!bus.ena_out && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (bus.ena_out !== 1'b1
              || bus.coef_rdy_out !== 1'b0
              || bus.dc !== exp_q[0].dc
              || int'(bus.out_dc) != exp_q[0].odc
              || int'(bus.run) != exp_q[0].run
              || int'(bus.size) != exp_q[0].size) begin
            errors++;
            $display("FAIL stall_hold got ena=%b rdy=%b dc=%b odc=%0d run=%0d size=%0d exp ena=1 rdy=0 dc=%b odc=%0d run=%0d size=%0d",
                     bus.ena_out, bus.coef_rdy_out, bus.dc,
                     bus.out_dc, bus.run, bus.size,
                     exp_q[0].dc, exp_q[0].odc,
                     exp_q[0].run, exp_q[0].size);
          end
        end
        @(posedge clk);
        #1 bus.rdy_in = 1'b1;
      end
    join
    drain();

    // 6: reset mid-block, then saturation extremes
    clr(); blk[0] = 33;
    push(1, 33, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) send(blk[i], 0);
    drain();
    rst = 1'b1;
    @(negedge clk);
    check_reset("reset_midblock");
    @(posedge clk);
    #1 rst = 1'b0;

    clr(); blk[0] = -7; blk[1] = 1023;
    push(1, -7, 0, 0, 0, 0);
    push(0, 0, 0, 10, 'h3FF, 0);
    push(0, 0, 0, 0, 0, 0);
    send_block(0); drain();

    clr(); blk[1] = -1024;
    push(1, 0, 0, 0, 0, 0);
    push(0, 0, 0, 10, 0, 0);
    push(0, 0, 0, 0, 0, 1);
    send_block(1); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
